tpu_regs: RTL

TPU_REGS -- requirements
Module: tpu_regs

---
 rtl/tpu_pkg.sv | 14 +
 rtl/tpu_regs.sv | 86 ++++++++
 2 files changed

// File: rtl/tpu_pkg.sv
// tpu_pkg: register addresses, CTRL bit positions and FSM states for tpu_regs.
package tpu_pkg;
    localparam logic [7:0] ADDR_CTRL     = 8'h00;
    localparam logic [7:0] ADDR_STATUS   = 8'h01;
    localparam logic [7:0] ADDR_TX_SLOT  = 8'h02;
    localparam logic [7:0] ADDR_RX_SLOT  = 8'h03;
    localparam logic [7:0] ADDR_TIMER_LO = 8'h04;
    localparam logic [7:0] ADDR_TIMER_HI = 8'h05;
    localparam int CTRL_RSTTPU      = 0;
    localparam int CTRL_TIMERINTMSK = 1;
    localparam int CTRL_TXSLOT_EN   = 2;
    localparam int CTRL_RXSLOT_EN   = 3;
    typedef enum logic {IDLE, COMMIT} state_t;
endpackage

// File: rtl/tpu_regs.sv
// tpu_regs: two-phase (accept/commit) write-only register block for the TPU timer.
// Optional TPU_REGS_SELFCLR_EN turns RSTTPU into a self-clearing one-cycle pulse.
module tpu_regs
    import tpu_pkg::*;
(
    input  logic        SYS_CLK,
    input  logic        SYS_RST,
    input  logic [7:0]  addr_out,
    input  logic [7:0]  data_out,
    input  logic        valid_out_m,
    output logic        ready_out,
    input  logic        TPUINT,
    output logic        RSTTPU,
    output logic        TIMERINTMSK,
    output logic        TXSLOT_EN,
    output logic        RXSLOT_EN,
    output logic        INTFLAG,
    output logic [7:0]  TX_SLOT,
    output logic [7:0]  RX_SLOT,
    output logic [15:0] TIMER_INT_VALUE,
    output logic        ADDR_ERR
);
    state_t     state;
    logic [7:0] addr_q;
    logic [7:0] data_q;
    logic [7:0] staging;
    logic       commit;
    logic       ctrl_wr;
    logic       clr_int;

    assign commit  = state == COMMIT;
    assign ctrl_wr = commit && addr_q == ADDR_CTRL;
    assign clr_int = commit && addr_q == ADDR_STATUS && data_q[0];

    always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            state           <= IDLE;
            ready_out       <= 1'b1;
            addr_q          <= '0;
            data_q          <= '0;
            staging         <= '0;
            RSTTPU          <= 1'b1;
            TIMERINTMSK     <= 1'b0;
            TXSLOT_EN       <= 1'b0;
            RXSLOT_EN       <= 1'b0;
            INTFLAG         <= 1'b0;
            TX_SLOT         <= '0;
            RX_SLOT         <= '0;
            TIMER_INT_VALUE <= '0;
            ADDR_ERR        <= 1'b0;
        end else begin
            // a new interrupt on the clearing edge must not be lost
            INTFLAG  <= TPUINT | (INTFLAG & ~clr_int);
            ADDR_ERR <= commit && addr_q > ADDR_TIMER_HI;
`ifdef TPU_REGS_SELFCLR_EN
            RSTTPU   <= ctrl_wr && data_q[CTRL_RSTTPU];
`else
            if (ctrl_wr)
                RSTTPU <= data_q[CTRL_RSTTPU];
`endif
            if (state == IDLE) begin
                if (valid_out_m) begin
                    addr_q    <= addr_out;
                    data_q    <= data_out;
                    state     <= COMMIT;
                    ready_out <= 1'b0;
                end
            end else begin
                state     <= IDLE;
                ready_out <= 1'b1;
                case (addr_q)
                    ADDR_CTRL: begin
                        TIMERINTMSK <= data_q[CTRL_TIMERINTMSK];
                        TXSLOT_EN   <= data_q[CTRL_TXSLOT_EN];
                        RXSLOT_EN   <= data_q[CTRL_RXSLOT_EN];
                    end
                    ADDR_TX_SLOT:  TX_SLOT <= data_q;
                    ADDR_RX_SLOT:  RX_SLOT <= data_q;
                    ADDR_TIMER_LO: staging <= data_q;
                    ADDR_TIMER_HI: TIMER_INT_VALUE <= {data_q, staging};
                    default: ;
                endcase
            end
        end
    end
endmodule
